// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states and sizing constants.
package arith_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/divider_32_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface divider_32_if
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  modport master (
    output in_valid, is_signed, in1, in2, out_ready,
    input  in_ready, out_valid, quot, rem, div_zero
  );

  modport slave (
    input  in_valid, is_signed, in1, in2, out_ready,
    output in_ready, out_valid, quot, rem, div_zero
  );
endinterface

// File: rtl/divider_32_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted  = {partial_rem, dividend_msb};
  // Extra top bit makes the trial sign visible even when the shifted value needs WIDTH+1 bits.
  assign trial    = shifted - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/divider_32.sv
// Iterative restoring divider, one quotient bit per cycle on operand magnitudes,
// with sign fix-up and single-cycle handling of divide-by-zero and signed overflow.
module divider_32
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  divider_32_if.slave   bus
);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   pr_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, quot_q, rem_q;
  logic             dz_q, neg_q, neg_r;

  logic             a_neg, b_neg, is_zero, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  assign a_neg   = bus.is_signed & bus.in1[WIDTH-1];
  assign b_neg   = bus.is_signed & bus.in2[WIDTH-1];
  assign a_mag   = a_neg ? -bus.in1 : bus.in1;
  assign b_mag   = b_neg ? -bus.in2 : bus.in2;
  assign is_zero = (bus.in2 == '0);
  assign is_ovf  = bus.is_signed & (bus.in1 == MIN_NEG) & (bus.in2 == '1);

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem  (pr_q),
    .dividend_msb (dvd_q[WIDTH-1]),
    .divisor      (dvs_q),
    .next_rem     (step_rem),
    .q_bit        (step_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = (is_zero | is_ovf) ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          if (is_zero) begin
            quot_q <= DIV_ZERO_QUOT;
            rem_q  <= bus.in1;
            dz_q   <= 1'b1;
          end else if (is_ovf) begin
            quot_q <= MIN_NEG;
            rem_q  <= '0;
            dz_q   <= 1'b0;
          end else begin
            dvd_q <= a_mag;
            dvs_q <= b_mag;
            pr_q  <= '0;
            cnt_q <= CNT_W'(WIDTH);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz_q  <= 1'b0;
          end
        end
        // Dividend register doubles as the quotient shift register.
        CALC: begin
          pr_q  <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          quot_q <= neg_q ? -dvd_q : dvd_q;
          rem_q  <= neg_r ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quot      = quot_q;
  assign bus.rem       = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_divider_32.sv
// Self-checking bench for divider_32: directed corner cases plus randomized operands
// against a plain-arithmetic reference model.
module tb_divider_32;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_32_if #(.WIDTH(W)) dif();
  divider_32 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

  int total = 0;
  int bad   = 0;

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return W + 2;
  endfunction

  // Drives one request, waits (bounded) for the result, samples it, then takes it.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output int cyc);
    @(negedge clk);
    dif.is_signed = s; dif.in1 = a; dif.in2 = b; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    cyc = 1;
    while (dif.out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    q = dif.quot; r = dif.rem; dz = dif.div_zero;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    total++; if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
    total++; if (dif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
    total++; if (dif.quot !== 32'd0) begin bad++; $display("FAIL reset_quot got %h want 0", dif.quot); end
    total++; if (dif.rem !== 32'd0) begin bad++; $display("FAIL reset_rem got %h want 0", dif.rem); end
    total++; if (dif.div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got %b want 0", dif.div_zero); end
  endtask

  task automatic test_directed;
    logic        ds [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] da [9] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                            32'd5, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] db [9] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'd9, 32'd5, 32'hFFFF_FFFE};
    logic [31:0] q, r, eq, er;
    logic dz, edz;
    int cyc;
    for (int i = 0; i < 9; i++) begin
      do_op(ds[i], da[i], db[i], q, r, dz, cyc);
      ref_div(ds[i], da[i], db[i], eq, er, edz);
      total++; if (q !== eq) begin bad++; $display("FAIL dir%0d_quot got %h want %h", i, q, eq); end
      total++; if (r !== er) begin bad++; $display("FAIL dir%0d_rem got %h want %h", i, r, er); end
      total++; if (dz !== edz) begin bad++; $display("FAIL dir%0d_div_zero got %b want %b", i, dz, edz); end
      total++; if (cyc != ref_lat(ds[i], da[i], db[i])) begin
        bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc, ref_lat(ds[i], da[i], db[i]));
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, q, r, eq, er;
    logic s, dz, edz;
    int cyc;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(1, 15));
        1: b = {$urandom} >> $urandom_range(0, 31);
        2: b = 32'd0;
        3: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      do_op(s, a, b, q, r, dz, cyc);
      ref_div(s, a, b, eq, er, edz);
      total++; if (q !== eq || r !== er || dz !== edz) begin
        bad++; $display("FAIL rnd%0d s=%b %h/%h got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                        i, s, a, b, q, r, dz, eq, er, edz);
      end
      total++; if (cyc != ref_lat(s, a, b)) begin
        bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, cyc, ref_lat(s, a, b));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] eq, er;
    logic edz;
    int cyc;
    ref_div(1'b0, 32'd1000, 32'd33, eq, er, edz);
    @(negedge clk);
    dif.is_signed = 1'b0; dif.in1 = 32'd1000; dif.in2 = 32'd33; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    cyc = 1;
    while (dif.out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc != W + 2) begin bad++; $display("FAIL bp_latency got %0d want %0d", cyc, W + 2); end
    // Offer a conflicting request while the result is held.
    dif.in1 = 32'd5; dif.in2 = 32'd0; dif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (dif.out_valid !== 1'b1 || dif.quot !== eq || dif.rem !== er || dif.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got v=%b q=%h r=%h rdy=%b want v=1 q=%h r=%h rdy=0",
                        i, dif.out_valid, dif.quot, dif.rem, dif.in_ready, eq, er);
      end
    end
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1) begin
        bad++; $display("FAIL bp_ignored%0d got v=%b rdy=%b want v=0 rdy=1", i, dif.out_valid, dif.in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q, r, eq, er;
    logic dz, edz;
    int cyc;
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, q, r, dz, cyc);
    ref_div(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er, edz);
    total++; if (dif.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", dif.in_ready); end
    total++; if (q !== eq || r !== er) begin bad++; $display("FAIL b2b_first got %h/%h want %h/%h", q, r, eq, er); end
    do_op(1'b0, 32'hDEAD_BEEF, 32'h0001_0000, q, r, dz, cyc);
    ref_div(1'b0, 32'hDEAD_BEEF, 32'h0001_0000, eq, er, edz);
    total++; if (q !== eq || r !== er || cyc != W + 2) begin
      bad++; $display("FAIL b2b_second got %h/%h lat %0d want %h/%h lat %0d", q, r, cyc, eq, er, W + 2);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q, r;
    logic dz;
    int cyc;
    @(negedge clk);
    dif.is_signed = 1'b0; dif.in1 = 32'd100; dif.in2 = 32'd7; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_busy got v=%b rdy=%b want v=0 rdy=0", dif.out_valid, dif.in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1 || dif.quot !== 32'd0 ||
                 dif.rem !== 32'd0 || dif.div_zero !== 1'b0) begin
      bad++; $display("FAIL mid_reset got v=%b rdy=%b q=%h r=%h dz=%b want v=0 rdy=1 q=0 r=0 dz=0",
                      dif.out_valid, dif.in_ready, dif.quot, dif.rem, dif.div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 32'd9, 32'd3, q, r, dz, cyc);
    total++; if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0 || cyc != W + 2) begin
      bad++; $display("FAIL mid_after got q=%h r=%h dz=%b lat %0d want q=3 r=0 dz=0 lat %0d", q, r, dz, cyc, W + 2);
    end
  endtask

  initial begin
    dif.in_valid = 1'b0; dif.is_signed = 1'b0; dif.in1 = '0; dif.in2 = '0; dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
